apb_exe_sequencer: RTL and testbench

//  APB master that shares the exe-unit slaves between NREQ requesters. Round-robin arbitration.

---
 rtl/apb_exe_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 16 +
 rtl/apb_exe_sequencer.sv | 114 +++++++++++
 tb/tb_apb_exe_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/apb_exe_pkg.sv
// apb_exe_pkg: shared state encoding, status codes and select decode for apb_exe_sequencer.
package apb_exe_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_WSETUP, S_WACCESS, S_GAP, S_RSETUP, S_RACCESS, S_RESP
  } state_t;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_DECERR  = 2'b10;
  function automatic logic [31:0] onehot(input logic [4:0] i);
    return 32'd1 << i;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);
  logic [NREQ-1:0] masked;
  // x & -x isolates the lowest set bit; fall back to the unmasked vector on wrap
  assign masked = req & ({NREQ{1'b1}} << ptr);
  assign gnt    = |masked ? masked & (~masked + 1'b1) : req & (~req + 1'b1);
  assign valid  = |req;
endmodule

// File: rtl/apb_exe_sequencer.sv
// apb_exe_sequencer: round-robin APB master running write/gap/read operations on exe-unit slaves.
module apb_exe_sequencer
  import apb_exe_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int SEL_WIDTH  = 3,
  parameter int IDX_W      = 2,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                       i_PCLK,
  input  logic                       i_PRESETn,
  input  logic [NREQ-1:0]            i_req,
  input  logic [NREQ*IDX_W-1:0]      i_req_idx,
  input  logic [NREQ*ADDR_WIDTH-1:0] i_req_op,
  input  logic [NREQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]            o_done,
  output logic [DATA_WIDTH-1:0]      o_rsp_data,
  output logic [3:0]                 o_rsp_err,
  output logic [1:0]                 o_rsp_status,
  output logic [SEL_WIDTH-1:0]       o_PSEL,
  output logic                       o_PENABLE,
  output logic                       o_PWRITE,
  output logic [ADDR_WIDTH-1:0]      o_PADDR,
  output logic [DATA_WIDTH-1:0]      o_PWDATA,
  input  logic                       i_PREADY,
  input  logic [DATA_WIDTH-1:0]      i_PRDATA,
  input  logic [3:0]                 i_PSLVERR
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES) + 1;
  state_t                st, st_n;
  logic [PW-1:0]         ptr, gidx;
  logic [NREQ-1:0]       gnt, gnt_q;
  logic                  gv, decerr, acc, bus, resp, tmo, gap_done;
  logic [IDX_W-1:0]      sel_idx, idx_q;
  logic [ADDR_WIDTH-1:0] sel_op, op_q;
  logic [DATA_WIDTH-1:0] sel_data, data_q, rdata_q;
  logic [3:0]            err_q;
  logic [1:0]            stat_q;
  logic [CW-1:0]         tmr;
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (.req(i_req), .ptr(ptr), .gnt(gnt), .valid(gv));
  always_comb begin
    gidx     = '0;
    sel_idx  = '0;
    sel_op   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        gidx     = PW'(i);
        sel_idx  = i_req_idx[i*IDX_W +: IDX_W];
        sel_op   = i_req_op[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  assign decerr   = 32'(sel_idx) >= SEL_WIDTH;
  assign acc      = st == S_WACCESS || st == S_RACCESS;
  assign bus      = acc || st == S_WSETUP || st == S_RSETUP;
  assign resp     = st == S_RESP;
  assign tmo      = acc && !i_PREADY && tmr == CW'(TIMEOUT - 1);
  assign gap_done = tmr == CW'(GAP_CYCLES - 1);
  always_comb begin
    st_n = st;
    case (st)
      S_IDLE:    st_n = !gv ? S_IDLE : decerr ? S_RESP : S_WSETUP;
      S_WSETUP:  st_n = S_WACCESS;
      S_WACCESS: st_n = i_PREADY ? S_GAP : tmo ? S_RESP : S_WACCESS;
      S_GAP:     st_n = gap_done ? S_RSETUP : S_GAP;
      S_RSETUP:  st_n = S_RACCESS;
      S_RACCESS: st_n = i_PREADY || tmo ? S_RESP : S_RACCESS;
      default:   st_n = S_IDLE;
    endcase
  end
  assign o_PSEL       = bus ? SEL_WIDTH'(onehot(5'(idx_q))) : '0;
  assign o_PENABLE    = acc;
  assign o_PWRITE     = st == S_WSETUP || st == S_WACCESS;
  assign o_PADDR      = bus ? op_q : '0;
  assign o_PWDATA     = bus ? data_q : '0;
  assign o_done       = resp ? gnt_q : '0;
  assign o_rsp_data   = resp ? rdata_q : '0;
  assign o_rsp_err    = resp ? err_q : '0;
  assign o_rsp_status = resp ? stat_q : '0;
  always_ff @(posedge i_PCLK or negedge i_PRESETn)
    if (!i_PRESETn) begin
      st      <= S_IDLE;
      ptr     <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      stat_q  <= ST_OK;
      tmr     <= '0;
    end else begin
      st  <= st_n;
      tmr <= st_n == st && st != S_IDLE ? tmr + 1'b1 : '0;
      if (st == S_IDLE && gv) begin
        gnt_q   <= gnt;
        idx_q   <= sel_idx;
        op_q    <= sel_op;
        data_q  <= sel_data;
        rdata_q <= '0;
        err_q   <= '0;
        stat_q  <= decerr ? ST_DECERR : ST_OK;
        ptr     <= gidx == PW'(NREQ - 1) ? '0 : gidx + 1'b1;
      end
      if (acc && i_PREADY) err_q <= err_q | i_PSLVERR;
      if (st == S_RACCESS && i_PREADY) rdata_q <= i_PRDATA;
      if (tmo) stat_q <= ST_TIMEOUT;
    end
endmodule

// File: tb/tb_apb_exe_sequencer.sv
// tb_apb_exe_sequencer: directed checks of arbitration, latency, timeout, decode error, PSLVERR and reset abort.
module tb_apb_exe_sequencer;
  logic        i_PCLK = 0, i_PRESETn = 0;
  logic [3:0]  i_req = 0;
  logic [7:0]  i_req_idx = 0, i_req_op = 0;
  logic [127:0] i_req_data = 0;
  logic [3:0]  o_done, o_rsp_err, i_PSLVERR;
  logic [31:0] o_rsp_data, o_PWDATA, i_PRDATA;
  logic [1:0]  o_rsp_status, o_PADDR;
  logic [2:0]  o_PSEL;
  logic        o_PENABLE, o_PWRITE, i_PREADY;
  logic        hang = 0, en_d = 0;
  logic [3:0]  werr = 0, rerr = 0;
  logic [31:0] res = 0;
  int passed = 0, total = 0;
  int n;
  logic [2:0] seen;
  logic rs, multi;

  apb_exe_sequencer dut (
    .i_PCLK(i_PCLK), .i_PRESETn(i_PRESETn), .i_req(i_req), .i_req_idx(i_req_idx),
    .i_req_op(i_req_op), .i_req_data(i_req_data), .o_done(o_done), .o_rsp_data(o_rsp_data),
    .o_rsp_err(o_rsp_err), .o_rsp_status(o_rsp_status), .o_PSEL(o_PSEL), .o_PENABLE(o_PENABLE),
    .o_PWRITE(o_PWRITE), .o_PADDR(o_PADDR), .o_PWDATA(o_PWDATA), .i_PREADY(i_PREADY),
    .i_PRDATA(i_PRDATA), .i_PSLVERR(i_PSLVERR)
  );

  always #5 i_PCLK = ~i_PCLK;

  // exe-unit slave: ready one cycle after PENABLE; op0 add, op1 multiply of the 16-bit halves
  assign i_PREADY  = !hang && o_PENABLE && en_d;
  assign i_PSLVERR = i_PREADY ? (o_PWRITE ? werr : rerr) : 4'b0;
  assign i_PRDATA  = res;
  always @(posedge i_PCLK) begin
    en_d <= o_PENABLE && !i_PREADY;
    if (o_PSEL != 0 && o_PENABLE && i_PREADY && o_PWRITE)
      res <= o_PADDR == 2'd1 ? {16'h0, o_PWDATA[15:0]} * {16'h0, o_PWDATA[31:16]}
                             : {16'h0, o_PWDATA[15:0]} + {16'h0, o_PWDATA[31:16]};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int r, input logic [1:0] idx, input logic [1:0] op, input logic [31:0] d);
    i_req_idx[r*2 +: 2]   = idx;
    i_req_op[r*2 +: 2]    = op;
    i_req_data[r*32 +: 32] = d;
  endtask

  task automatic run(input int budget, output int cyc, output logic [2:0] sn, output logic r, output logic m);
    cyc = 0; sn = 0; r = 0; m = 0;
    do begin
      @(negedge i_PCLK);
      cyc++;
      sn |= o_PSEL;
      if ($countones(o_PSEL) > 1) m = 1;
      if (o_PSEL != 0 && !o_PWRITE && !o_PENABLE) r = 1;
    end while (o_done == 0 && cyc < budget);
    chk("done_within_budget", 64'(o_done != 0), 64'd1);
  endtask

  task automatic reset_dut();
    i_PRESETn = 0;
    repeat (2) @(negedge i_PCLK);
    i_PRESETn = 1;
  endtask

  initial begin
    reset_dut();
    chk("reset_ctl", {o_done, o_rsp_data, o_rsp_err, o_rsp_status, o_PSEL, o_PENABLE, o_PWRITE, o_PADDR}, 64'd0);
    chk("reset_pwdata", 64'(o_PWDATA), 64'd0);

    set_req(0, 2'd2, 2'd1, {16'd3, 16'd5});
    i_req = 4'b0001;
    run(40, n, seen, rs, multi);
    i_req = 0;
    chk("t1_latency", 64'(n), 64'd9);
    chk("t1_done", 64'(o_done), 64'b0001);
    chk("t1_data", 64'(o_rsp_data), 64'd15);
    chk("t1_status", 64'(o_rsp_status), 64'd0);
    chk("t1_err", 64'(o_rsp_err), 64'd0);
    chk("t1_psel", 64'(seen), 64'b100);
    chk("t1_multihot", 64'(multi), 64'd0);
    @(negedge i_PCLK);
    chk("t1_pulse_one_cycle", {o_done, o_rsp_data}, 64'd0);

    set_req(1, 2'd3, 2'd0, 32'h1234_5678);
    i_req = 4'b0010;
    run(40, n, seen, rs, multi);
    i_req = 0;
    chk("t4_latency", 64'(n), 64'd1);
    chk("t4_done", 64'(o_done), 64'b0010);
    chk("t4_status", 64'(o_rsp_status), 64'b10);
    chk("t4_no_psel", 64'(seen), 64'd0);
    @(negedge i_PCLK);

    werr = 4'b0001; rerr = 4'b0100;
    set_req(2, 2'd0, 2'd0, {16'd10, 16'd20});
    i_req = 4'b0100;
    run(40, n, seen, rs, multi);
    i_req = 0;
    werr = 0; rerr = 0;
    chk("t5_done", 64'(o_done), 64'b0100);
    chk("t5_err", 64'(o_rsp_err), 64'b0101);
    chk("t5_data", 64'(o_rsp_data), 64'd30);
    chk("t5_psel", 64'(seen), 64'b001);
    @(negedge i_PCLK);

    hang = 1;
    set_req(3, 2'd1, 2'd1, {16'd7, 16'd9});
    i_req = 4'b1000;
    run(60, n, seen, rs, multi);
    i_req = 0;
    hang = 0;
    chk("t3_latency", 64'(n), 64'd18);
    chk("t3_done", 64'(o_done), 64'b1000);
    chk("t3_status", 64'(o_rsp_status), 64'b01);
    chk("t3_data", 64'(o_rsp_data), 64'd0);
    chk("t3_no_rsetup", 64'(rs), 64'd0);
    @(negedge i_PCLK);

    for (int r = 0; r < 4; r++) set_req(r, 2'd0, 2'd0, 32'h0001_0001);
    i_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run(40, n, seen, rs, multi);
      chk("t2_grant", 64'(o_done), 64'(4'b0001 << (k % 4)));
      chk("t2_latency", 64'(n), k == 0 ? 64'd9 : 64'd10);
    end
    i_req = 0;
    @(negedge i_PCLK);

    set_req(1, 2'd0, 2'd1, {16'd2, 16'd7});
    i_req = 4'b0010;
    repeat (7) @(negedge i_PCLK);
    chk("t6_in_raccess", {o_PSEL, o_PENABLE, o_PWRITE}, {3'b001, 1'b1, 1'b0});
    i_PRESETn = 0;
    #1;
    chk("t6_reset_ctl", {o_done, o_rsp_data, o_rsp_err, o_rsp_status, o_PSEL, o_PENABLE, o_PWRITE, o_PADDR}, 64'd0);
    chk("t6_reset_pwdata", 64'(o_PWDATA), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_PCLK);
      chk("t6_no_done_in_reset", 64'(o_done), 64'd0);
    end
    set_req(2, 2'd0, 2'd0, {16'd1, 16'd1});
    i_req = 4'b0110;
    i_PRESETn = 1;
    run(40, n, seen, rs, multi);
    i_req = 0;
    chk("t6_restart_ptr0", 64'(o_done), 64'b0010);
    chk("t6_data", 64'(o_rsp_data), 64'd14);
    chk("t6_latency", 64'(n), 64'd9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
